dmem_responder: RTL

Data-memory responder on the far side of the MEM stage's RAM interface. It accepts the MEM stage's address, write data and write enable, and returns read data combinationally in the same cycle. It also decodes a small memory-mapped I/O window (LED register, cycle counter, status) and serves a four-phase debug load/dump port that borrows the array only in cycles where the core is not writing. It sits at top level beside the pipeline and is the only storage behind `mem_read_data`.

---
 rtl/dmem_responder_pkg.sv | 16 +
 rtl/dmem_responder_if.sv | 28 ++
 rtl/dmem_array.sv | 27 ++
 rtl/dmem_responder.sv | 117 +++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: I/O window offsets,
// default window base and debug handshake state encodings.
package dmem_responder_pkg;

    localparam logic [15:0] IO_BASE_DEF = 16'hFF00;

    localparam logic [15:0] IO_LED    = 16'd0;
    localparam logic [15:0] IO_CYCLE  = 16'd1;
    localparam logic [15:0] IO_STATUS = 16'd2;

    typedef enum logic {
        DBG_IDLE = 1'b0,
        DBG_ACK  = 1'b1
    } dbg_state_e;

endpackage

// File: rtl/dmem_responder_if.sv
// Core MEM-stage RAM bus plus the four-phase debug load/dump port.
interface dmem_responder_if;

    logic [15:0] ex_alu_result;
    logic [15:0] mem_write_data;
    logic        mem_write_en;
    logic [15:0] mem_read_data;

    logic        dbg_req;
    logic        dbg_we;
    logic [15:0] dbg_addr;
    logic [15:0] dbg_wdata;
    logic        dbg_ack;
    logic [15:0] dbg_rdata;

    modport master (
        output ex_alu_result, mem_write_data, mem_write_en,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  mem_read_data, dbg_ack, dbg_rdata
    );

    modport slave (
        input  ex_alu_result, mem_write_data, mem_write_en,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output mem_read_data, dbg_ack, dbg_rdata
    );

endinterface

// File: rtl/dmem_array.sv
// 2^ADDR_W x 16 word storage: one synchronous write port, two asynchronous
// read ports (core and debug). Contents are deliberately not reset.
module dmem_array #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [15:0]       wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [15:0]       rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [15:0]       rdata_b
);

    logic [15:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: RAM plus LED/CYCLE/STATUS I/O window, with a debug
// port that only borrows the write path in cycles the core is not writing.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int          ADDR_W  = 8,
    parameter logic [15:0] IO_BASE = IO_BASE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    dmem_responder_if.slave   bus,
    output logic [15:0]       led_out
);

    dbg_state_e  state;
    dbg_state_e  next_state;
    logic [15:0] cycle_cnt;
    logic [15:0] core_ram;
    logic [15:0] dbg_ram;
    logic        dbg_go;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    logic [15:0] wr_off;
    logic        wr_io;
    logic [15:0] dbg_rd;

    function automatic logic [15:0] decode_read(
        input logic [15:0] addr,
        input logic [15:0] ram_word,
        input logic [15:0] cnt,
        input logic [15:0] led,
        input logic        ack
    );
        logic [15:0] off;
        off = addr - IO_BASE;
        if (addr < IO_BASE) begin
            return ram_word;
        end
        case (off)
            IO_LED:    return led;
            IO_CYCLE:  return cnt;
            IO_STATUS: return {15'b0, ack};
            default:   return 16'h0000;
        endcase
    endfunction

    // The core always owns the write path; debug is granted only when it is idle.
    assign dbg_go  = (state == DBG_IDLE) && bus.dbg_req && !bus.mem_write_en;
    assign wr_en   = bus.mem_write_en || (dbg_go && bus.dbg_we);
    assign wr_addr = bus.mem_write_en ? bus.ex_alu_result  : bus.dbg_addr;
    assign wr_data = bus.mem_write_en ? bus.mem_write_data : bus.dbg_wdata;
    assign wr_io   = (wr_addr >= IO_BASE);
    assign wr_off  = wr_addr - IO_BASE;

    dmem_array #(.ADDR_W(ADDR_W)) u_array (
        .clk     (clk),
        .we      (wr_en && !wr_io),
        .waddr   (wr_addr[ADDR_W-1:0]),
        .wdata   (wr_data),
        .raddr_a (bus.ex_alu_result[ADDR_W-1:0]),
        .rdata_a (core_ram),
        .raddr_b (bus.dbg_addr[ADDR_W-1:0]),
        .rdata_b (dbg_ram)
    );

    assign bus.dbg_ack       = (state == DBG_ACK);
    assign bus.mem_read_data = decode_read(bus.ex_alu_result, core_ram, cycle_cnt,
                                           led_out, bus.dbg_ack);
    assign dbg_rd            = decode_read(bus.dbg_addr, dbg_ram, cycle_cnt,
                                           led_out, bus.dbg_ack);

    always_ff @(posedge clk) begin
        if (rst) begin
            led_out <= 16'h0000;
        end else if (wr_en && wr_io && (wr_off == IO_LED)) begin
            led_out <= wr_data;
        end
    end

    // A write to CYCLE beats the increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt <= 16'h0000;
        end else if (wr_en && wr_io && (wr_off == IO_CYCLE)) begin
            cycle_cnt <= 16'h0000;
        end else begin
            cycle_cnt <= cycle_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.dbg_rdata <= 16'h0000;
        end else if (dbg_go && !bus.dbg_we) begin
            bus.dbg_rdata <= dbg_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DBG_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            DBG_IDLE: if (dbg_go)       next_state = DBG_ACK;
            DBG_ACK:  if (!bus.dbg_req) next_state = DBG_IDLE;
            default:  next_state = DBG_IDLE;
        endcase
    end

endmodule
